// File: rtl/uart_autobaud.sv
// ============================================================================
// Module   : uart_autobaud
// Purpose  : Measures the bit widths of a 0x55 sync character on the serial
//            rx line and reports the matching 2-bit baud_rate code. This is the
//            same encoding that baud_gen.baud_rate uses. Lock is taken once
//            per rearm.
// Options  : AUTOBAUD_RETRY_EN - when defined, a failed detection returns to
//            WAIT_IDLE on the next cycle, so detection retries on its own.
//            When undefined, ERROR holds until rearm or reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_autobaud #(
  parameter int unsigned CNT_W   = 15,
  parameter int unsigned MIN_BIT = 1302,
  parameter int unsigned TH_19K2 = 3906,
  parameter int unsigned TH_9K6  = 7812,
  parameter int unsigned TH_4K8  = 15625,
  parameter int unsigned MAX_BIT = 31250
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  input  logic       rearm,
  output logic [1:0] baud_rate,
  output logic       locked,
  output logic       busy,
  output logic       det_error
);

  // Thresholds at counter width, so every compare is an unsigned compare
  // between equal-width operands.
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_BIT);
  localparam logic [CNT_W-1:0] T19_V   = CNT_W'(TH_19K2);
  localparam logic [CNT_W-1:0] T96_V   = CNT_W'(TH_9K6);
  localparam logic [CNT_W-1:0] T48_V   = CNT_W'(TH_4K8);
  localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_BIT);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LAST_IDX = 4'd8;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_MEASURE   = 3'd2,
    S_LOCKED    = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             rx_dly;
  logic             rx_edge;
  logic             rx_fall;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [1:0]       cand;
  logic [1:0]       cls_code;
  logic             cls_err;
  logic             idle_ok;
  logic             mismatch;

  // Two-flop synchronizer followed by a delay flop for edge detection.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      rx_dly <= 1'b1;
    end else begin
      sync1  <= rx;
      sync2  <= sync1;
      rx_dly <= sync2;
    end
  end

  // An edge is any difference between the two most recent synced samples.
  assign rx_edge = sync2 ^ rx_dly;
  assign rx_fall = rx_dly & ~sync2;

  // Edge-to-edge width counter: the value seen on an edge is the pulse width.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rx_edge) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_TOP) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Map the current width onto a rate code. The checks are ordered from the
  // narrowest width to the widest.
  always_comb begin
    cls_err  = 1'b0;
    cls_code = 2'b00;
    if (cnt < MIN_V) begin
      cls_err = 1'b1;
    end else if (cnt < T19_V) begin
      cls_code = 2'b11;
    end else if (cnt < T96_V) begin
      cls_code = 2'b10;
    end else if (cnt < T48_V) begin
      cls_code = 2'b01;
    end else if (cnt <= MAX_V) begin
      cls_code = 2'b00;
    end else begin
      cls_err = 1'b1;
    end
  end

  // The counter doubles as the idle-high timer. It restarts on every edge,
  // so a high line with a count of at least MIN_BIT has been quiet long enough.
  assign idle_ok  = sync2 & ~rx_edge & (cnt >= MIN_V);

  // After the first pulse, every pulse must fall in the same rate class.
  assign mismatch = (idx != 4'd0) && (cls_code != cand);

  // Detection state machine. All outputs are registered here.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= S_WAIT_IDLE;
      idx       <= 4'd0;
      cand      <= 2'b00;
      baud_rate <= 2'b10;
      locked    <= 1'b0;
      busy      <= 1'b0;
      det_error <= 1'b0;
    end else begin
      det_error <= 1'b0;
      if (rearm) begin
        // rearm takes priority over any edge or lock in the same cycle.
        state  <= S_WAIT_IDLE;
        locked <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_WAIT_IDLE: begin
            if (idle_ok) begin
              state <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (rx_fall) begin
              state <= S_MEASURE;
              idx   <= 4'd0;
              busy  <= 1'b1;
            end
          end
          S_MEASURE: begin
            if (rx_edge) begin
              if (cls_err || mismatch) begin
                state     <= S_ERROR;
                busy      <= 1'b0;
                det_error <= 1'b1;
              end else begin
                if (idx == 4'd0) begin
                  cand <= cls_code;
                end
                idx <= idx + 4'd1;
                if (idx == LAST_IDX) begin
                  baud_rate <= cls_code;
                  locked    <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_LOCKED;
                end
              end
            end else if (cnt > MAX_V) begin
              // The line has been quiet longer than the slowest legal bit.
              state     <= S_ERROR;
              busy      <= 1'b0;
              det_error <= 1'b1;
            end
          end
          S_LOCKED: begin
            state <= S_LOCKED;
          end
          S_ERROR: begin
`ifdef AUTOBAUD_RETRY_EN
            state <= S_WAIT_IDLE;
`else
            state <= S_ERROR;
`endif
          end
          default: begin
            state <= S_WAIT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
